// File: rtl/eth_idma_desc_queue.sv
// Descriptor FIFO and issue controller in front of the iDMA backend.
// Caps in-flight transfers, consumes responses and keeps completion/error status.
package eth_idma_desc_queue_pkg;
    typedef struct packed {
        logic last;
        logic error;
    } idma_rsp_default_t;
endpackage

// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | accept pushes, issue head while under the outstanding cap
// ST_FLUSH | FIFO emptied, no issue; wait for outstanding responses to drain
module eth_idma_desc_queue #(
    parameter int unsigned QueueDepth     = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter type idma_req_t = logic,
    parameter type idma_rsp_t = eth_idma_desc_queue_pkg::idma_rsp_default_t,
    localparam int unsigned PtrW = $clog2(QueueDepth),
    localparam int unsigned LvlW = $clog2(QueueDepth + 1),
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  idma_req_t       desc_i,
    input  logic            desc_push_i,
    output logic            desc_full_o,
    output logic [LvlW-1:0] queue_level_o,
    output idma_req_t       idma_req_o,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    input  idma_rsp_t       idma_rsp_i,
    input  logic            rsp_valid_i,
    output logic            rsp_ready_o,
    input  logic            flush_i,
    input  logic            irq_clear_i,
    output logic [31:0]     done_cnt_o,
    output logic [15:0]     err_cnt_o,
    output logic            overflow_o,
    output logic            unexp_rsp_o,
    output logic            irq_o,
    output logic            busy_o
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]      state_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [LvlW-1:0] level_q;
    logic [OutW-1:0] outst_q;
    idma_req_t       mem_q [QueueDepth];

    logic fifo_full;
    logic fifo_empty;
    logic in_run;
    logic flush_now;
    logic push_attempt;
    logic push_ok;
    logic push_drop;
    logic issue;
    logic rsp_dec;
    logic rsp_flag;

    assign fifo_full    = (level_q == LvlW'(QueueDepth));
    assign fifo_empty   = (level_q == '0);
    assign in_run       = (state_q == ST_RUN);
    assign flush_now    = in_run && flush_i;
    // Pushes during a flush cycle or in FLUSH vanish without flagging overflow.
    assign push_attempt = desc_push_i && in_run && !flush_i;
    assign push_ok      = push_attempt && !fifo_full;
    assign push_drop    = push_attempt && fifo_full;

    assign req_valid_o  = in_run && !fifo_empty && (outst_q < OutW'(MaxOutstanding));
    assign issue        = req_valid_o && req_ready_i;
    assign rsp_dec      = rsp_valid_i && (outst_q != '0);
    assign rsp_flag     = rsp_valid_i && (idma_rsp_i.last || idma_rsp_i.error);

    assign idma_req_o    = mem_q[rd_ptr_q];
    assign desc_full_o   = fifo_full;
    assign queue_level_o = level_q;
    assign busy_o        = !fifo_empty || (outst_q != '0);
    assign rsp_ready_o   = 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(QueueDepth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= desc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_now) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, issue})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // An issue in the flush cycle still counts as in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q <= '0;
        end else begin
            case ({issue, rsp_dec})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: outst_q <= outst_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:   if (flush_i) state_q <= ST_FLUSH;
                ST_FLUSH: if (outst_q == '0) state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_cnt_o  <= '0;
            err_cnt_o   <= '0;
            overflow_o  <= 1'b0;
            unexp_rsp_o <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            if (rsp_valid_i) begin
                done_cnt_o <= done_cnt_o + 32'd1;
            end
            if (rsp_valid_i && idma_rsp_i.error && (err_cnt_o != 16'hFFFF)) begin
                err_cnt_o <= err_cnt_o + 16'd1;
            end
            if (push_drop) begin
                overflow_o <= 1'b1;
            end
            if (rsp_valid_i && (outst_q == '0)) begin
                unexp_rsp_o <= 1'b1;
            end
            if (rsp_flag) begin
                irq_o <= 1'b1;
            end else if (irq_clear_i) begin
                irq_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_idma_desc_queue.sv
// Directed bench for eth_idma_desc_queue: expected issue order kept in a
// scoreboard queue, status outputs checked against hand-computed values.
module tb_eth_idma_desc_queue;

    typedef logic [31:0] req_t;
    typedef struct packed {
        logic last;
        logic error;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    req_t        desc = '0;
    logic        desc_push = 1'b0;
    logic        desc_full;
    logic [2:0]  queue_level;
    req_t        idma_req;
    logic        req_valid;
    logic        req_ready = 1'b0;
    rsp_t        idma_rsp = '0;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic        flush = 1'b0;
    logic        irq_clear = 1'b0;
    logic [31:0] done_cnt;
    logic [15:0] err_cnt;
    logic        overflow;
    logic        unexp_rsp;
    logic        irq;
    logic        busy;

    int   n_chk = 0;
    int   n_fail = 0;
    req_t exp_q [$];

    eth_idma_desc_queue #(
        .QueueDepth    (4),
        .MaxOutstanding(3),
        .idma_req_t    (req_t),
        .idma_rsp_t    (rsp_t)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .desc_i       (desc),
        .desc_push_i  (desc_push),
        .desc_full_o  (desc_full),
        .queue_level_o(queue_level),
        .idma_req_o   (idma_req),
        .req_valid_o  (req_valid),
        .req_ready_i  (req_ready),
        .idma_rsp_i   (idma_rsp),
        .rsp_valid_i  (rsp_valid),
        .rsp_ready_o  (rsp_ready),
        .flush_i      (flush),
        .irq_clear_i  (irq_clear),
        .done_cnt_o   (done_cnt),
        .err_cnt_o    (err_cnt),
        .overflow_o   (overflow),
        .unexp_rsp_o  (unexp_rsp),
        .irq_o        (irq),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input req_t d, input bit will_issue);
        desc = d;
        desc_push = 1'b1;
        if (will_issue) exp_q.push_back(d);
        tick();
        desc_push = 1'b0;
    endtask

    task automatic respond(input logic last, input logic error);
        rsp_valid = 1'b1;
        idma_rsp = '{last: last, error: error};
        tick();
        rsp_valid = 1'b0;
        idma_rsp = '0;
    endtask

    // Monitor: every request handshake must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && req_valid && req_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL issue_order: got 0x%0h, expected no request", idma_req);
            end else begin
                chk("issue_order", idma_req, exp_q.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_rsp_ready", {31'd0, rsp_ready}, 32'd1);
        chk("rst_idma_req", idma_req, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Three back-to-back pushes with ready high, then three responses.
        req_ready = 1'b1;
        push(32'hA000_0001, 1'b1);
        push(32'hA000_0002, 1'b1);
        push(32'hA000_0003, 1'b1);
        tick();
        chk("t1_level", {29'd0, queue_level}, 32'd0);
        chk("t1_busy_outst", {31'd0, busy}, 32'd1);
        chk("t1_issued_all", exp_q.size(), 32'd0);
        respond(1'b0, 1'b0);
        respond(1'b0, 1'b0);
        chk("t1_irq_before_last", {31'd0, irq}, 32'd0);
        respond(1'b1, 1'b0);
        chk("t1_done", done_cnt, 32'd3);
        chk("t1_irq", {31'd0, irq}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chk("t1_irq_clear", {31'd0, irq}, 32'd0);

        // Outstanding cap (3): fourth descriptor waits for a response.
        push(32'hB000_0001, 1'b1);
        push(32'hB000_0002, 1'b1);
        push(32'hB000_0003, 1'b1);
        push(32'hB000_0004, 1'b1);
        tick();
        tick();
        chk("t2_capped_valid", {31'd0, req_valid}, 32'd0);
        chk("t2_capped_level", {29'd0, queue_level}, 32'd1);
        chk("t2_pending", exp_q.size(), 32'd1);
        respond(1'b0, 1'b0);
        chk("t2_valid_after_rsp", {31'd0, req_valid}, 32'd1);
        tick();
        chk("t2_level_after", {29'd0, queue_level}, 32'd0);
        chk("t2_pending_after", exp_q.size(), 32'd0);
        respond(1'b0, 1'b0);
        respond(1'b0, 1'b0);
        respond(1'b0, 1'b0);
        chk("t2_done", done_cnt, 32'd7);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        chk("t2_irq", {31'd0, irq}, 32'd0);

        // Fill with ready low; fifth push overflows and is never issued.
        req_ready = 1'b0;
        push(32'hC000_0001, 1'b1);
        push(32'hC000_0002, 1'b1);
        push(32'hC000_0003, 1'b1);
        push(32'hC000_0004, 1'b1);
        push(32'hC000_0005, 1'b0);
        chk("t3_level", {29'd0, queue_level}, 32'd4);
        chk("t3_full", {31'd0, desc_full}, 32'd1);
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        tick();
        chk("t3_head_stable", idma_req, 32'hC000_0001);
        chk("t3_valid_stable", {31'd0, req_valid}, 32'd1);
        req_ready = 1'b1;
        tick();
        rsp_valid = 1'b1;
        tick();
        tick();
        tick();
        tick();
        rsp_valid = 1'b0;
        tick();
        chk("t3_done", done_cnt, 32'd11);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_unexp", {31'd0, unexp_rsp}, 32'd0);
        chk("t3_drained", exp_q.size(), 32'd0);

        // Flush with two queued and one outstanding.
        push(32'hD000_0001, 1'b1);
        tick();
        req_ready = 1'b0;
        push(32'hD000_0002, 1'b0);
        push(32'hD000_0003, 1'b0);
        chk("t4_level_pre", {29'd0, queue_level}, 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_level_flush", {29'd0, queue_level}, 32'd0);
        chk("t4_valid_flush", {31'd0, req_valid}, 32'd0);
        chk("t4_busy_flush", {31'd0, busy}, 32'd1);
        req_ready = 1'b1;
        push(32'hDEAD_0000, 1'b0);
        chk("t4_push_dropped", {29'd0, queue_level}, 32'd0);
        chk("t4_no_overflow_change", {31'd0, overflow}, 32'd1);
        respond(1'b0, 1'b0);
        tick();
        push(32'hE000_0001, 1'b1);
        tick();
        chk("t4_run_issue", exp_q.size(), 32'd0);
        chk("t4_busy_run", {31'd0, busy}, 32'd1);
        respond(1'b0, 1'b0);
        chk("t4_done", done_cnt, 32'd13);
        chk("t4_busy_end", {31'd0, busy}, 32'd0);

        // Response with nothing outstanding.
        respond(1'b0, 1'b0);
        chk("t5_unexp", {31'd0, unexp_rsp}, 32'd1);
        chk("t5_done", done_cnt, 32'd14);
        chk("t5_busy", {31'd0, busy}, 32'd0);

        // Error counter saturation and irq set-over-clear.
        for (int i = 0; i < 32'h10002; i++) begin
            rsp_valid = 1'b1;
            idma_rsp = '{last: 1'b0, error: 1'b1};
            irq_clear = (i == 32'h10001);
            tick();
        end
        rsp_valid = 1'b0;
        idma_rsp = '0;
        irq_clear = 1'b0;
        chk("t6_err_sat", {16'd0, err_cnt}, 32'h0000_FFFF);
        chk("t6_done", done_cnt, 32'h0001_0010);
        chk("t6_irq_set_wins", {31'd0, irq}, 32'd1);

        // Asynchronous reset mid-burst.
        push(32'hF000_0000, 1'b1);
        tick();
        req_ready = 1'b0;
        push(32'hF000_0001, 1'b0);
        push(32'hF000_0002, 1'b0);
        chk("t7_level_pre", {29'd0, queue_level}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_level", {29'd0, queue_level}, 32'd0);
        chk("t7_rst_full_busy", {30'd0, desc_full, busy}, 32'd0);
        chk("t7_rst_valid", {31'd0, req_valid}, 32'd0);
        chk("t7_rst_idma_req", idma_req, 32'd0);
        chk("t7_rst_done", done_cnt, 32'd0);
        chk("t7_rst_err", {16'd0, err_cnt}, 32'd0);
        chk("t7_rst_flags", {29'd0, overflow, unexp_rsp, irq}, 32'd0);
        chk("t7_rst_rsp_ready", {31'd0, rsp_ready}, 32'd1);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        respond(1'b0, 1'b0);
        chk("t7_late_rsp_unexp", {31'd0, unexp_rsp}, 32'd1);
        chk("t7_late_rsp_done", done_cnt, 32'd1);
        chk("t7_late_rsp_busy", {31'd0, busy}, 32'd0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
